// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit constants and packed-BCD helpers
// used by the multi-digit counter and its per-digit step logic.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    function automatic logic is_valid_bcd(input bcd_digit_t digit);
        return digit <= BCD_NINE;
    endfunction

    // Packed-BCD magnitude a <= b over the low n digits (n up to 8); the most
    // significant differing digit decides, equal values compare as true.
    function automatic logic bcd_le(input logic [31:0] a, input logic [31:0] b, input int n);
        logic le;
        le = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                if (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > b[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                    le = 1'b0;
                else if (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] < b[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                    le = 1'b1;
            end
        end
        return le;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single BCD digit step: increments or decrements one digit when
// step_in is set and reports a carry/borrow into the next digit.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       step_in,
    input  logic       up_dn,
    output logic [3:0] digit_next,
    output logic       step_out
);

    always_comb begin
        digit_next = digit;
        step_out   = 1'b0;
        if (step_in) begin
            if (up_dn) begin
                if (digit == BCD_NINE) begin
                    digit_next = BCD_ZERO;
                    step_out   = 1'b1;
                end else begin
                    digit_next = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_ZERO) begin
                    digit_next = BCD_NINE;
                    step_out   = 1'b1;
                end else begin
                    digit_next = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit packed-BCD up/down counter with clear, validated parallel load,
// programmable terminal value and registered wrap / load-reject pulses.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int                        NUM_DIGITS  = 4,
    parameter logic [4*NUM_DIGITS-1:0]   MAX_VALUE   = {NUM_DIGITS{4'h9}},
    parameter logic [4*NUM_DIGITS-1:0]   RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic                      en,
    input  logic                      up_dn,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      tc,
    output logic                      load_err
);

    localparam int W = BCD_DIGIT_W * NUM_DIGITS;

    logic [W-1:0]        count_q, count_d;
    logic                tc_q, tc_d;
    logic                load_err_q, load_err_d;
    logic [W-1:0]        count_step;
    logic [NUM_DIGITS:0] step;
    logic                step_unused;
    logic [31:0]         load_val_ext;
    logic [31:0]         max_ext;
    logic                digits_valid;
    logic                load_ok;

    // Digit 0 always steps; the chain decides how far the carry/borrow reaches.
    assign step[0]     = 1'b1;
    assign step_unused = step[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (count_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .step_in    (step[g]),
            .up_dn      (up_dn),
            .digit_next (count_step[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .step_out   (step[g+1])
        );
    end

    assign load_val_ext = 32'(load_val);
    assign max_ext      = 32'(MAX_VALUE);

    always_comb begin
        digits_valid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_valid_bcd(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                digits_valid = 1'b0;
        end
    end

    assign load_ok = digits_valid && bcd_le(load_val_ext, max_ext, NUM_DIGITS);

    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            if (load_ok)
                count_d = load_val;
            else
                load_err_d = 1'b1;
        end else if (en) begin
            // Terminal wrap overrides the digit chain so count never exceeds MAX_VALUE.
            if (up_dn) begin
                if (count_q == MAX_VALUE) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_step;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VALUE;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= RESET_VALUE;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: a 3-digit 000..999 instance and a 2-digit
// 00..59 instance with a non-zero reset value, checked with immediate assertions.
module tb_bcd_counter;

    logic        clk;
    logic        rst_n;

    logic        clear3, load3, en3, up3;
    logic [11:0] lv3;
    logic [11:0] count3;
    logic        tc3, le3;

    logic        clear2, load2, en2, up2;
    logic [7:0]  lv2;
    logic [7:0]  count2;
    logic        tc2, le2;

    int checks;
    int errors;

    bcd_counter #(
        .NUM_DIGITS  (3),
        .MAX_VALUE   (12'h999),
        .RESET_VALUE (12'h000)
    ) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear3),
        .load     (load3),
        .load_val (lv3),
        .en       (en3),
        .up_dn    (up3),
        .count    (count3),
        .tc       (tc3),
        .load_err (le3)
    );

    bcd_counter #(
        .NUM_DIGITS  (2),
        .MAX_VALUE   (8'h59),
        .RESET_VALUE (8'h25)
    ) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear2),
        .load     (load2),
        .load_val (lv2),
        .en       (en2),
        .up_dn    (up2),
        .count    (count2),
        .tc       (tc2),
        .load_err (le2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp3;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear3 = 1'b0; load3 = 1'b0; en3 = 1'b0; up3 = 1'b1; lv3 = '0;
        clear2 = 1'b0; load2 = 1'b0; en2 = 1'b0; up2 = 1'b1; lv2 = '0;

        #12;
        chk("rst_count3", 32'(count3), 32'h000);
        chk("rst_tc3",    32'(tc3),    32'h0);
        chk("rst_le3",    32'(le3),    32'h0);
        chk("rst_count2", 32'(count2), 32'h25);
        chk("rst_tc2",    32'(tc2),    32'h0);

        // Release between edges, then count up from zero.
        #5;
        rst_n = 1'b1;
        en3   = 1'b1;
        up3   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp3 = 12'(((i / 10) << 4) | (i % 10));
            chk("up_count3", 32'(count3), 32'(exp3));
            chk("up_tc3",    32'(tc3),    32'h0);
        end

        // Multi-digit carry and terminal wrap.
        en3 = 1'b0; load3 = 1'b1; lv3 = 12'h998;
        tick();
        chk("load998", 32'(count3), 32'h998);
        chk("load998_le", 32'(le3), 32'h0);
        load3 = 1'b0; en3 = 1'b1;
        tick();
        chk("c999",    32'(count3), 32'h999);
        chk("c999_tc", 32'(tc3),    32'h0);
        tick();
        chk("wrap000",    32'(count3), 32'h000);
        chk("wrap000_tc", 32'(tc3),    32'h1);
        tick();
        chk("after_wrap",    32'(count3), 32'h001);
        chk("after_wrap_tc", 32'(tc3),    32'h0);
        en3 = 1'b0;

        // Custom terminal 59: up wrap, down wrap, direction change.
        load2 = 1'b1; lv2 = 8'h58;
        tick();
        chk("load58", 32'(count2), 32'h58);
        load2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
        tick();
        chk("c59",    32'(count2), 32'h59);
        chk("c59_tc", 32'(tc2),    32'h0);
        tick();
        chk("c00_wrap",    32'(count2), 32'h00);
        chk("c00_wrap_tc", 32'(tc2),    32'h1);
        up2 = 1'b0;
        tick();
        chk("dn_wrap59",    32'(count2), 32'h59);
        chk("dn_wrap59_tc", 32'(tc2),    32'h1);
        tick();
        chk("dn58",    32'(count2), 32'h58);
        chk("dn58_tc", 32'(tc2),    32'h0);
        up2 = 1'b1;
        tick();
        chk("dirchg59", 32'(count2), 32'h59);
        en2 = 1'b0;
        tick();
        chk("hold59",    32'(count2), 32'h59);
        chk("hold59_tc", 32'(tc2),    32'h0);

        // Load validation.
        load2 = 1'b1; lv2 = 8'h3A;
        tick();
        chk("rej3A_count", 32'(count2), 32'h59);
        chk("rej3A_le",    32'(le2),    32'h1);
        lv2 = 8'h60;
        tick();
        chk("rej60_count", 32'(count2), 32'h59);
        chk("rej60_le",    32'(le2),    32'h1);
        load2 = 1'b0;
        tick();
        chk("le_pulse_end", 32'(le2), 32'h0);
        load2 = 1'b1; lv2 = 8'h42;
        tick();
        chk("load42",    32'(count2), 32'h42);
        chk("load42_le", 32'(le2),    32'h0);
        lv2 = 8'h59;
        tick();
        chk("load59_edge", 32'(count2), 32'h59);
        chk("load59_le",   32'(le2),    32'h0);

        // Priority: clear beats load beats enable.
        clear2 = 1'b1; load2 = 1'b1; lv2 = 8'h17; en2 = 1'b1; up2 = 1'b1;
        tick();
        chk("prio_clear",    32'(count2), 32'h00);
        chk("prio_clear_tc", 32'(tc2),    32'h0);
        chk("prio_clear_le", 32'(le2),    32'h0);
        clear2 = 1'b0;
        tick();
        chk("prio_load", 32'(count2), 32'h17);
        load2 = 1'b0;
        tick();
        chk("post_load_inc", 32'(count2), 32'h18);
        en2 = 1'b0;

        // Asynchronous reset in the middle of a count.
        load3 = 1'b1; lv3 = 12'h537;
        tick();
        chk("load537", 32'(count3), 32'h537);
        load3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
        tick();
        chk("c538", 32'(count3), 32'h538);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_count3", 32'(count3), 32'h000);
        chk("async_tc3",    32'(tc3),    32'h0);
        chk("async_count2", 32'(count2), 32'h25);
        #2;
        rst_n = 1'b1;
        tick();
        chk("resume001", 32'(count3), 32'h001);
        tick();
        chk("resume002", 32'(count3), 32'h002);
        en3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
